// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  value_we,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = (DEAD == 0) ? '0 : CW'(DEAD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [4*DIGITS-1:0]   act_val_q, act_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0]   sh_val_q, sh_val_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic                  pend_q, pend_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  wrap;
    logic [DIGITS-1:0]     lzb;
    logic [3:0]            nib;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h7B;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Frame boundary: the edge that leaves SHOW of the last digit.
    assign wrap = en && (state_q == SHOW) && (cnt_q == DIV_LAST)
                  && (idx_q == IDX_LAST);

    // Shadow/active value handling; active only changes at frame boundaries
    // while scanning, so a frame never mixes two values.
    always_comb begin
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        pend_d    = pend_q;
        if (!en || wrap) begin
            if (value_we) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
            end else if (pend_q) begin
                act_val_d = sh_val_q;
                act_dp_d  = sh_dp_q;
            end
            pend_d = 1'b0;
        end else if (value_we) begin
            sh_val_d = value_in;
            sh_dp_d  = dp_in;
            pend_d   = 1'b1;
        end
    end

`ifdef SEVENSEG_LZB_EN
    always_comb begin
        logic hi_nz;
        hi_nz = 1'b0;
        lzb   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_nz  = hi_nz | (act_val_d[4*i +: 4] != 4'h0);
            lzb[i] = !hi_nz;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (DEAD == 0 || cnt_q == DEAD_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = '0;
                        state_d = (DEAD == 0) ? SHOW : BLANK;
                        tick_d  = wrap;
                        idx_d   = wrap ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs follow the next state so they change on the same edge.
    assign nib = act_val_d[{idx_d, 2'b00} +: 4];

    always_comb begin
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '1;
        if (state_d == SHOW) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (idx_d != IW'(i));
            end
            seg_d = lzb[idx_d] ? 7'h00 : dec7(nib);
            dp_d  = act_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            idx_q     <= '0;
            cnt_q     <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            pend_q    <= 1'b0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            an_q      <= '1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: time-position reference model plus directed checks.
// Define SEVENSEG_LZB_EN for both files to cover leading-zero blanking.
module tb_sevenseg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int DEAD   = 2;
    localparam int SLOT   = DIV + DEAD;
    localparam int FRAME  = DIGITS * SLOT;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        value_we = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int vectors = 0;
    int errors  = 0;
    int seen3f  = 0;

    always #5 clk = ~clk;

    sevenseg_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .value_in(value_in), .dp_in(dp_in), .value_we(value_we),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    // Reference: mc counts enabled edges since scan start; the display
    // position within a frame follows directly from it.
    int          mc;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    bit          m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc = 0; m_act = '0; m_sh = '0;
            m_adp = '0; m_sdp = '0; m_pend = 0;
        end else if (!en) begin
            if (value_we) begin m_act = value_in; m_adp = dp_in; end
            else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; end
            m_pend = 0;
            mc = 0;
        end else begin
            mc++;
            if (mc % FRAME == 0) begin
                if (value_we) begin m_act = value_in; m_adp = dp_in; end
                else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; end
                m_pend = 0;
            end else if (value_we) begin
                m_sh = value_in; m_sdp = dp_in; m_pend = 1;
            end
        end
    end

    int          pos, slot, w;
    logic        lit;
    logic [15:0] upper;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;

    always @(negedge clk) begin
        pos   = mc % FRAME;
        slot  = pos / SLOT;
        w     = pos % SLOT;
        lit   = (w >= DEAD);
        upper = m_act >> (4 * slot);
        e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
        e_seg = lit ? SEGTAB[upper[3:0]] : 7'h00;
`ifdef SEVENSEG_LZB_EN
        if (lit && slot > 0 && upper == 16'h0) e_seg = 7'h00;
`endif
        e_dp   = lit ? m_adp[slot] : 1'b0;
        e_tick = (mc > 0) && (pos == 0);
        vectors++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp
            || frame_tick !== e_tick) begin
            errors++;
            $display("FAIL model t=%0t: an=%b seg=%h dp=%b tick=%b, want an=%b seg=%h dp=%b tick=%b",
                     $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (seg === 7'h3F) seen3f++;
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] a,
                       input logic [6:0] s, input logic d);
        vectors++;
        if (an !== a || seg !== s || dp !== d) begin
            errors++;
            $display("FAIL %s: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     nm, an, seg, dp, a, s, d);
        end
    endtask

    task automatic chk_tick(input string nm, input logic t);
        vectors++;
        if (frame_tick !== t) begin
            errors++;
            $display("FAIL %s: frame_tick=%b, want %b", nm, frame_tick, t);
        end
    endtask

    task automatic wait_an(input string nm, input logic [3:0] tgt);
        int n = 0;
        while (an !== tgt && n < 200) begin cyc(1); n++; end
        vectors++;
        if (an !== tgt) begin
            errors++;
            $display("FAIL %s: an=%b, want %b within 200 cycles", nm, an, tgt);
        end
    endtask

    task automatic wait_tick(input string nm);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin cyc(1); n++; end
        vectors++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_tick=%b, want 1 within 200 cycles", nm, frame_tick);
        end
    endtask

    task automatic wr(input logic [15:0] v, input logic [3:0] d);
        value_in = v; dp_in = d; value_we = 1'b1;
        cyc(1);
        value_we = 1'b0;
    endtask

    initial begin
        int last, nt;
        logic [3:0] prev_an;

        cyc(2);
        chk("reset_dark", 4'hF, 7'h00, 1'b0);
        chk_tick("reset_tick", 1'b0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_dark", 4'hF, 7'h00, 1'b0);

        wr(16'h12A4, 4'b0010);
        en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cyc(1);
            case (k)
                1:  chk("lead_blank", 4'hF, 7'h00, 1'b0);
                2:  chk("d0_first", 4'b1110, 7'h66, 1'b0);
                5:  chk("d0_last", 4'b1110, 7'h66, 1'b0);
                6:  chk("gap0", 4'hF, 7'h00, 1'b0);
                8:  chk("d1", 4'b1101, 7'h77, 1'b1);
                14: chk("d2", 4'b1011, 7'h5B, 1'b0);
                20: chk("d3", 4'b0111, 7'h06, 1'b0);
                24: chk_tick("first_tick", 1'b1);
                25: chk_tick("tick_one_cycle", 1'b0);
                default: ;
            endcase
        end

        last = -1; nt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            prev_an = an;
            cyc(1);
            if (frame_tick === 1'b1) begin
                vectors++;
                if (prev_an !== 4'b0111) begin
                    errors++;
                    $display("FAIL tick_align: an before tick=%b, want 0111", prev_an);
                end
                if (last >= 0) begin
                    vectors++;
                    if (i - last != FRAME) begin
                        errors++;
                        $display("FAIL tick_period: got %0d, want %0d", i - last, FRAME);
                    end
                end
                last = i;
                nt++;
            end
        end
        vectors++;
        if (nt != 3) begin
            errors++;
            $display("FAIL tick_count: got %0d, want 3", nt);
        end

        wait_an("tear_wait_d1", 4'b1101);
        seen3f = 0;
        wr(16'h0000, 4'h0);
        wr(16'hFFFF, 4'h0);
        wait_an("tear_wait_d2", 4'b1011);
        chk("tear_old_d2", 4'b1011, 7'h5B, 1'b0);
        wait_an("tear_wait_d3", 4'b0111);
        chk("tear_old_d3", 4'b0111, 7'h06, 1'b0);
        wait_tick("tear_tick");
        wait_an("tear_new_d0w", 4'b1110);
        chk("tear_new_d0", 4'b1110, 7'h71, 1'b0);
        wait_an("tear_new_d3w", 4'b0111);
        chk("tear_new_d3", 4'b0111, 7'h71, 1'b0);
        vectors++;
        if (seen3f != 0) begin
            errors++;
            $display("FAIL no_zero_shown: %0d cycles with seg=3F, want 0", seen3f);
        end

        begin
            int n = 0;
            while (mc % FRAME != FRAME - 1 && n < 200) begin cyc(1); n++; end
        end
        wr(16'h8888, 4'h0);
        chk_tick("collide_tick", 1'b1);
        wait_an("collide_d0w", 4'b1110);
        chk("collide_d0", 4'b1110, 7'h7F, 1'b0);
        wait_an("collide_d3w", 4'b0111);
        chk("collide_d3", 4'b0111, 7'h7F, 1'b0);

        wait_an("drop_wait", 4'b1011);
        en = 1'b0;
        cyc(1);
        chk("drop_dark", 4'hF, 7'h00, 1'b0);
        chk_tick("drop_tick", 1'b0);
        cyc(3);
        chk("drop_hold", 4'hF, 7'h00, 1'b0);
        en = 1'b1;
        cyc(1);
        chk("restart_blank", 4'hF, 7'h00, 1'b0);
        cyc(1);
        chk("restart_d0", 4'b1110, 7'h7F, 1'b0);

`ifdef SEVENSEG_LZB_EN
        en = 1'b0;
        wr(16'h0050, 4'h0);
        en = 1'b1;
        wait_an("lzb_d0w", 4'b1110);
        chk("lzb_d0", 4'b1110, 7'h3F, 1'b0);
        wait_an("lzb_d1w", 4'b1101);
        chk("lzb_d1", 4'b1101, 7'h6D, 1'b0);
        wait_an("lzb_d2w", 4'b1011);
        chk("lzb_d2", 4'b1011, 7'h00, 1'b0);
        wait_an("lzb_d3w", 4'b0111);
        chk("lzb_d3", 4'b0111, 7'h00, 1'b0);
        en = 1'b0;
        wr(16'h0000, 4'h0);
        en = 1'b1;
        wait_an("lzb0_d0w", 4'b1110);
        chk("lzb0_d0", 4'b1110, 7'h3F, 1'b0);
        wait_an("lzb0_d1w", 4'b1101);
        chk("lzb0_d1", 4'b1101, 7'h00, 1'b0);
`endif

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) begin
                value_in = 16'($urandom);
                dp_in    = 4'($urandom);
                value_we = 1'b1;
            end else begin
                value_we = 1'b0;
            end
            cyc(1);
        end
        value_we = 1'b0;

        en = 1'b1;
        wait_an("rst_wait", 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 4'hF, 7'h00, 1'b0);
        chk_tick("async_reset_tick", 1'b0);
        en = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(3);
        chk("post_reset_hold", 4'hF, 7'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexed scan controller for a common-segment multi-digit seven-segment display.
- Holds a DIGITS-nibble display value and decodes one nibble at a time onto a shared segment bus.
- Walks the digit enables with programmable on-time and ghost-suppression dead time.
- Sits between the numeric datapath (counters, debug registers) and the board display pins; new values are applied tear-free at frame boundaries.

Parameters:
- DIGITS, 4, number of digits scanned (>=1)
- DIV, 50000, clock cycles each digit is lit (>=1)
- DEAD, 8, clock cycles all digits are off between digits (>=0; 0 = no blank gap)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable
- value_in  input  4*DIGITS  display value; nibble i shown on digit i, digit 0 = bits [3:0]
- dp_in  input  DIGITS  decimal point per digit
- value_we  input  1  one-cycle write strobe for value_in/dp_in
- seg  output  7  segments, active-high, bit0=a .. bit6=g
- dp  output  1  decimal point of the lit digit, active-high
- an  output  DIGITS  digit enables, active-low one-cold, all 1 = dark
- frame_tick  output  1  one-cycle pulse at end of each full scan

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state: an all 1, seg=0, dp=0, frame_tick=0, state BLANK, digit index 0, cycle counter 0, active and shadow value/dp 0, pending 0.
- All outputs are registered. They take the new state's values on the same edge the state changes.
- Two-state FSM:
  - BLANK: an all 1, seg=0, dp=0, for DEAD cycles, then go to SHOW of the current index.
  - SHOW: an[idx]=0 only, seg=decode(active nibble idx), dp=active dp[idx], for DIV cycles, then go to BLANK with idx+1.
  - If DEAD=0, BLANK is skipped and SHOW goes directly to SHOW of the next digit.
- Wrap-around: the edge leaving SHOW of idx=DIGITS-1 sets idx=0 and pulses frame_tick for one cycle. This is the frame boundary.
- Frame period: DIGITS*(DIV+DEAD) cycles.
- Decode table (hex 0-F → seg): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 7B 71.
- Writes while en=1:
  - value_we copies value_in/dp_in into the shadow and sets pending.
  - Repeated writes before the boundary: last write wins.
  - At the frame boundary, if pending, shadow moves to active and pending clears.
  - A write in the same cycle as the boundary goes straight to active and pending stays clear.
- Writes while en=0: value_we writes active directly; no pending.
- en falling: on the next edge go to BLANK, idx=0, counter=0, frame_tick=0, an all 1. Any pending shadow moves to active.
- en rising: scan starts with DEAD blank cycles (none if DEAD=0), then digit 0.
- The counter is wide enough for max(DIV,DEAD) and never wraps mid-state.
- Reset mid-SHOW forces an dark immediately, asynchronously.

Optional Feature:
- Macro: SEVENSEG_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit above the most-significant nonzero nibble of the active value shows seg=0. Its an is still asserted for timing uniformity, and its dp is still driven from dp_in.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - The blank decision is computed from the active value only.
- Not defined: every digit shows its decoded nibble; no extra logic is present.

Test Plan:
- Config for all scenarios: DIGITS=4, DIV=4, DEAD=2.
- Reset: assert rst_n=0 mid-SHOW → an=4'b1111, seg=0, dp=0, frame_tick=0 without waiting for clk. Outputs hold after release while en=0.
- Idle load + scan: en=0, write value 0x12A4 with dp_in=4'b0010, then en=1 →
  - 2 cycles an=1111
  - 4 cycles an=1110 seg=0x66
  - 2 cycles dark
  - 4 cycles an=1101 seg=0x77 dp=1
  - then 0x5B on an=1011, 0x06 on an=0111
- Frame timing: free-run 3 frames → frame_tick high exactly 1 cycle every 24 cycles, coincident with an leaving 0111.
- Tear-free update: while digit 1 is lit, write 0x0000 then 0xFFFF → digits 2 and 3 still show the old value this frame. After frame_tick, all digits show 0x71. 0x0000 is never displayed.
- Boundary collision and en drop:
  - Write 0x8888 in the frame_tick cycle → the next frame shows 0x7F on all digits.
  - Drop en mid-SHOW → an=1111 next cycle, and scan restarts at digit 0 after re-enable.
- With SEVENSEG_LZB_EN: active value 0x0050 → digits 3 and 2 seg=0 with an still pulsing, digit 1 seg=0x6D, digit 0 seg=0x3F. Value 0x0000 → only digit 0 shows 0x3F.
